song_recorder: RTL
==================

Name: song_recorder

Overview:
- Captures notes played live on the keyboard as (note, duration) entries in an internal record RAM.
- The auto-player can later replay the RAM in place of a ROM song.
- Sits between the keyboard note decoder and the playback path; it is the writer side of the song-memory interface the player reads.
- Read port is asynchronous (address in, note/duration out), matching the song ROM read timing.

Parameters:
- SIZE, 32: number of entries in the record RAM.
- ADDR_W, 5: entry address width; SIZE = 2**ADDR_W.
- DUR_W, 16: duration field width, in ticks.
- TICK_DIV, 1: clk cycles per duration tick. 1 gives the same units as the player's duration counter.
- STABLE_CYCLES, 4: clk cycles a new note value must hold before it is accepted.
- QUANT, 8: quantization step in ticks, power of 2. Used only with REC_QUANTIZE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- record_en  in  1  level. Rising edge arms a new take; falling edge ends it.
- note_in  in  4  live keyboard note; 0 = rest (no key).
- read_addr  in  ADDR_W  playback read address.
- read_note  out  4  note stored at read_addr (combinational).
- read_duration  out  DUR_W  duration stored at read_addr (combinational).
- length  out  ADDR_W+1  number of valid entries, 0..SIZE.
- recording  out  1  high in ARMED or MEASURE.
- full  out  1  high when length == SIZE.
- wr_pulse  out  1  one-cycle strobe on each entry write.

Behaviour:
- Reset (reset=0, async): state IDLE, length=0, recording=0, full=0, wr_pulse=0, tick and duration counters 0. RAM contents are not cleared.
- Input path: note_in passes through a 2-FF synchronizer, then a stability filter.
  - A value is accepted once it has differed from the current accepted note for STABLE_CYCLES consecutive cycles.
  - Shorter glitches are ignored; their time counts toward the current note.
- Tick generator: free-runs while in MEASURE; pulses once per TICK_DIV cycles.
- States:
  - IDLE: on record_en rising edge → ARMED; length ← 0, full ← 0.
  - ARMED: waits for the first accepted non-zero note. Leading rests are never stored.
    - On accept → MEASURE; cur_note ← note, dur ← 0.
    - record_en low → IDLE.
  - MEASURE: dur increments on each tick, saturating at 2**DUR_W−1. Saturation does not split the segment.
    - On an accepted change → COMMIT with (cur_note, dur). The next segment then starts with the new note (rests included, as note 0) and dur ← 0.
    - On record_en low → COMMIT of the current segment if cur_note ≠ 0; a trailing rest is dropped. Then → DONE.
  - COMMIT (one cycle): RAM[length] ← {note, dur}; length ← length+1; wr_pulse=1.
    - If length+1 == SIZE → DONE, full=1.
    - Otherwise return to MEASURE, or go to DONE if the take is ending.
  - DONE: recording=0. record_en must go low and then rise again to start a new take (→ ARMED).
- Durations span from one note's acceptance to the next's acceptance.
- Simultaneous accepted change and record_en fall in the same cycle: the fall wins. The segment is committed (if non-rest) and the new note is discarded.
- A segment with dur=0 (change accepted before the first tick) is stored with duration 1.
- Read during write to the same address: read_* shows the new data from the cycle after the write edge.
- reset asserted mid-take: immediate IDLE, length=0. Partial RAM data is kept but invalid.

Optional Feature:
- Macro: REC_QUANTIZE_EN.
- Defined: the committed duration is rounded to the nearest multiple of QUANT (ties round up), minimum QUANT, saturating at the largest multiple of QUANT that fits in DUR_W.
- Undefined: the raw duration is stored, with only the minimum-1 rule applied.

Decomposition:
- Shared package:
  - NOTE_W=4
  - NOTE_REST=4'd0
  - DUR_W=16
  - SONG_SIZE=32
  - recorder state enum (IDLE, ARMED, MEASURE, COMMIT, DONE)
- Sub-module: note_stabilizer (2-FF sync plus STABLE_CYCLES filter; outputs accepted note and a one-cycle accept pulse).

Test Plan (TICK_DIV=1, STABLE_CYCLES=4 unless noted):
- Arm, note_in=0 for 50 cycles, then 3 for 100, 5 for 60, drop record_en → length=2; entry0=(3,100), entry1=(5,60); rest not stored.
- During note 3, pulse note_in=7 for 2 cycles → no new entry; entry0 duration includes the glitch cycles.
- Sequence 3,0,3 (40 cycles each), stop during the final 3 → entries (3,40), (0,40), (3,k); stop during a trailing rest → that rest is absent.
- Play 33 alternating notes of 10 cycles → full=1 after 32 wr_pulses; entry 32 ignored; DONE until record_en is re-armed.
- Assert reset low mid-MEASURE with length=3 → length=0, recording=0 immediately, without waiting for a clk edge.
- With REC_QUANTIZE_EN, QUANT=8: raw durations 11, 12, 3 → stored 8, 16, 8.

Source files
------------

// File: rtl/song_recorder_pkg.sv
// Shared types and constants for the song recorder: note/duration widths,
// record RAM depth and the recorder state encoding.
package song_recorder_pkg;

    localparam int NOTE_W    = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam int DUR_W     = 16;
    localparam int SONG_SIZE = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        MEASURE = 3'd2,
        COMMIT  = 3'd3,
        DONE    = 3'd4
    } rec_state_e;

endpackage

// File: rtl/song_recorder_note_stabilizer.sv
// Keyboard note conditioning: 2-FF synchronizer followed by a filter that
// accepts a new value only after it has been held for STABLE_CYCLES cycles.
module note_stabilizer
    import song_recorder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note_in,
    output logic [NOTE_W-1:0] note_out,
    output logic              accept_out
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    logic [NOTE_W-1:0] sync1_q, sync2_q;
    logic [NOTE_W-1:0] cand_q, cand_d;
    logic [NOTE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  run_s;
    logic              accept_q, accept_d;

    // Filter: count consecutive cycles of one candidate value differing from the accepted note.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        accept_d = 1'b0;
        run_s    = CNT_W'(1);
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else begin
            if ((sync2_q == cand_q) && (cnt_q != '0)) begin
                run_s = cnt_q + CNT_W'(1);
            end else begin
                run_s = CNT_W'(1);
            end
            cand_d = sync2_q;
            if (run_s >= CNT_TARGET) begin
                acc_d    = sync2_q;
                accept_d = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = run_s;
            end
        end
    end

    // Synchronizer and filter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= NOTE_REST;
            sync2_q  <= NOTE_REST;
            cand_q   <= NOTE_REST;
            acc_q    <= NOTE_REST;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= note_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    assign note_out   = acc_q;
    assign accept_out = accept_q;

endmodule

// File: rtl/song_recorder.sv
// Live note recorder: captures (note, duration) segments into a record RAM
// with an asynchronous read port. Macro REC_QUANTIZE_EN enables duration quantization.
module song_recorder
    import song_recorder_pkg::*;
#(
    parameter int SIZE          = SONG_SIZE,
    parameter int ADDR_W        = 5,
    parameter int DUR_W         = song_recorder_pkg::DUR_W,
    parameter int TICK_DIV      = 1,
    parameter int STABLE_CYCLES = 4,
    parameter int QUANT         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              record_en,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [NOTE_W-1:0] read_note,
    output logic [DUR_W-1:0]  read_duration,
    output logic [ADDR_W:0]   length,
    output logic              recording,
    output logic              full,
    output logic              wr_pulse
);

`ifdef REC_QUANTIZE_EN
    localparam bit QUANT_EN = 1'b1;
`else
    localparam bit QUANT_EN = 1'b0;
`endif

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  DUR_MAX   = {DUR_W{1'b1}};
    localparam logic [DUR_W:0]    Q_STEP    = (DUR_W+1)'(QUANT);
    localparam logic [DUR_W:0]    Q_HALF    = (DUR_W+1)'(QUANT / 2);
    localparam logic [DUR_W:0]    Q_MAX     = (DUR_W+1)'((((2 ** DUR_W) - 1) / QUANT) * QUANT);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(SIZE - 1);

    // Stored duration: never zero; optionally rounded to the nearest QUANT step.
    function automatic logic [DUR_W-1:0] store_dur(input logic [DUR_W-1:0] raw);
        logic [DUR_W:0] rounded;
        if (QUANT_EN) begin
            rounded = ({1'b0, raw} + Q_HALF) & ~(Q_STEP - (DUR_W+1)'(1));
            if (rounded < Q_STEP) begin
                rounded = Q_STEP;
            end else if (rounded > Q_MAX) begin
                rounded = Q_MAX;
            end
            return rounded[DUR_W-1:0];
        end else begin
            return (raw == '0) ? DUR_W'(1) : raw;
        end
    endfunction

    rec_state_e        state_q, state_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic              full_q, full_d;
    logic              recording_q, recording_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic              rec_prev_q;
    logic              ending_q, ending_d;
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;
    logic [NOTE_W-1:0] com_note_q, com_note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  com_dur_q, com_dur_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [NOTE_W+DUR_W-1:0] mem_q [SIZE];

    logic [NOTE_W-1:0] acc_note_s;
    logic              accept_s;
    logic              rise_s;
    logic              tick_active_s;
    logic              tick_s;
    logic [DUR_W-1:0]  dur_inc_s;

    note_stabilizer #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clk        (clk),
        .reset      (reset),
        .note_in    (note_in),
        .note_out   (acc_note_s),
        .accept_out (accept_s)
    );

    assign rise_s        = record_en & ~rec_prev_q;
    assign tick_active_s = (state_q == MEASURE) || (state_q == COMMIT);
    assign tick_s        = tick_active_s && (tick_cnt_q == TICK_LAST);
    assign dur_inc_s     = (tick_s && (dur_q != DUR_MAX)) ? dur_q + DUR_W'(1) : dur_q;

    // Tick divider runs only while a segment is being timed.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!tick_active_s || tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    // Recorder FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        full_d     = full_q;
        ending_d   = ending_q;
        cur_note_d = cur_note_q;
        com_note_d = com_note_q;
        dur_d      = dur_q;
        com_dur_d  = com_dur_q;
        case (state_q)
            IDLE, DONE: begin
                if (rise_s) begin
                    state_d  = ARMED;
                    length_d = '0;
                    full_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ARMED: begin
                if (!record_en) begin
                    state_d = IDLE;
                end else if (accept_s && (acc_note_s != NOTE_REST)) begin
                    state_d    = MEASURE;
                    cur_note_d = acc_note_s;
                    dur_d      = '0;
                end else begin
                    state_d = ARMED;
                end
            end
            MEASURE: begin
                // A falling record_en takes priority over a simultaneous note change.
                if (!record_en) begin
                    if (cur_note_q != NOTE_REST) begin
                        state_d    = COMMIT;
                        com_note_d = cur_note_q;
                        com_dur_d  = store_dur(dur_inc_s);
                        ending_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else if (accept_s) begin
                    state_d    = COMMIT;
                    com_note_d = cur_note_q;
                    com_dur_d  = store_dur(dur_inc_s);
                    ending_d   = 1'b0;
                    cur_note_d = acc_note_s;
                    dur_d      = '0;
                end else begin
                    dur_d = dur_inc_s;
                end
            end
            COMMIT: begin
                dur_d    = dur_inc_s;
                length_d = length_q + (ADDR_W+1)'(1);
                if (length_q == LAST_IDX) begin
                    state_d = DONE;
                    full_d  = 1'b1;
                end else if (ending_q) begin
                    state_d = DONE;
                end else begin
                    state_d = MEASURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        recording_d = (state_d == ARMED) || (state_d == MEASURE);
        wr_pulse_d  = (state_d == COMMIT);
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            length_q    <= '0;
            full_q      <= 1'b0;
            recording_q <= 1'b0;
            wr_pulse_q  <= 1'b0;
            rec_prev_q  <= 1'b0;
            ending_q    <= 1'b0;
            cur_note_q  <= NOTE_REST;
            com_note_q  <= NOTE_REST;
            dur_q       <= '0;
            com_dur_q   <= '0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            full_q      <= full_d;
            recording_q <= recording_d;
            wr_pulse_q  <= wr_pulse_d;
            rec_prev_q  <= record_en;
            ending_q    <= ending_d;
            cur_note_q  <= cur_note_d;
            com_note_q  <= com_note_d;
            dur_q       <= dur_d;
            com_dur_q   <= com_dur_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    // Record RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state_q == COMMIT) begin
            mem_q[length_q[ADDR_W-1:0]] <= {com_note_q, com_dur_q};
        end
    end

    assign {read_note, read_duration} = mem_q[read_addr];
    assign length    = length_q;
    assign full      = full_q;
    assign recording = recording_q;
    assign wr_pulse  = wr_pulse_q;

endmodule
